voice_bus_sequencer: RTL and testbench
======================================

# voice_bus_sequencer

Bus master that turns queued note events into register-write transactions on the voice register bus of `TopLevel`. Upstream logic posts note-on/note-off events through a valid/ready port; the block buffers them in a small FIFO. It then issues the ordered write sequence (Incr, WaveType, PulseWidth, Sustain, Gate) with the standard three-cycle BusClock strobe. This removes hand-sequenced bus writes from the control path. Shadow registers suppress redundant parameter writes.

## Interface
- `BASE_ADDR`, 16'h0010: address of the Gate register. Incr, WaveType, PulseWidth and Sustain are at +1 through +4.
- `DEPTH`, 4: event FIFO entries (power of two, ≥2).
- `Clock` in 1: system clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `EvValid` in 1: event offered.
- `EvReady` out 1: FIFO can accept; equals !full (registered).
- `EvNoteOn` in 1: 1 = note-on, 0 = note-off.
- `EvIncr` in 8: phase increment.
- `EvWaveType` in 2: waveform select; zero-extended to 8 bits on the bus.
- `EvPulseWidth` in 8: pulse width.
- `EvSustain` in 8: sustain level.
- `BusAddress` out 16: write address.
- `BusData` out 8: write data. Write-only driver; top level tristates it with `BusReadWrite`.
- `BusReadWrite` out 1: 1 while a write transaction is in progress.
- `BusClock` out 1: write strobe; slaves capture on its rising edge.
- `Busy` out 1: event being sequenced.

## Operation
- FSM states: IDLE, LOAD, SETUP, STROBE, HOLD.
- IDLE: if the FIFO is non-empty, pop the head into the working register and go to LOAD.
- LOAD builds the write list in fixed order:
  - Note-on with gate open: Gate=0 (retrigger), then the note-on list below.
  - Note-on with gate closed: Incr, WaveType, PulseWidth, Sustain, then Gate=1. A parameter write is skipped when its shadow is valid and equal to the new value. Gate=1 is never skipped.
  - Note-off with gate open: Gate=0 only.
  - Note-off with gate closed: empty list. The event is dropped and the FSM returns to IDLE.
- Each write takes three cycles:
  - SETUP: address and data driven, RW=1, BusClock=0.
  - STROBE: BusClock=1.
  - HOLD: BusClock=0.
- After HOLD, go to the SETUP of the next list item. If the list is exhausted, go to IDLE.
- On each HOLD, update the corresponding shadow register and set its valid bit. The gate-open flag follows the last Gate value written.
- FIFO push: EvValid && EvReady. Pop happens only in IDLE. Push and pop may occur in the same cycle.
- Arithmetic:
  - Addresses are BASE_ADDR + offset in 16 bits; wrap modulo 2^16.
  - FIFO pointers are log2(DEPTH)+1 bits with wrap-around.

## Timing
- Reset values:
  - Outputs: BusAddress=0, BusData=0, BusReadWrite=0, BusClock=0, Busy=0, EvReady=1.
  - Internal state: FIFO empty, shadow valid bits cleared, gate flag closed, FSM in IDLE.
- Reset mid-transaction: all outputs go to their reset values immediately (asynchronously). Queued events are discarded and no partial write completes.
- Latency, with an event accepted at edge N into an empty FIFO while the FSM is IDLE:
  - LOAD in cycle N+1.
  - First SETUP (BusReadWrite rises) in cycle N+2.
  - BusClock high in cycle N+3.
- Outputs are registered. BusAddress and BusData are stable from SETUP through HOLD; BusClock is high for exactly one cycle per write.
- Between consecutive writes of one event there is no idle cycle: HOLD is followed directly by the next SETUP.
- Between events: at least one IDLE cycle and one LOAD cycle. BusReadWrite=0 and BusAddress/BusData return to 0 in IDLE and LOAD.
- Busy=1 from LOAD through the final HOLD.
- An event that is dropped or has an empty list still costs two cycles: IDLE then LOAD.
- Full FIFO:
  - EvReady=0. An offered event is not accepted and EvValid must be held.
  - A pop in cycle K raises EvReady in cycle K+1, not in the same cycle.
- Empty FIFO: the FSM remains in IDLE, Busy=0.
- Full note-on from reset: 5 writes = 15 bus cycles plus 1 LOAD cycle.

## Test plan
- Reset, then note-on (Incr=0x0F, WaveType=1, PW=0x3F, Sustain=0x7F). Expect writes 0x0011=0F, 0x0012=01, 0x0013=3F, 0x0014=7F, 0x0010=01 in that order. Each write has BusClock high for 1 cycle; first SETUP at N+2; Busy low after 15 bus cycles.
- Then note-on (Incr=0x05, PW=0x7F, other fields unchanged). Expect exactly 0x0010=00, 0x0011=05, 0x0013=7F, 0x0010=01 (retrigger; WaveType and Sustain skipped).
- Note-off, then a second note-off. Expect a single write 0x0010=00; the second note-off produces no bus activity and Busy pulses for 1 cycle.
- Push 5 events back-to-back with DEPTH=4 while the FSM is busy. Expect EvReady=0 after the 4th. The 5th is accepted the cycle after the first pop, and all 5 sequences then complete in order.
- Assert Reset during the STROBE of the second write. Expect BusClock, BusReadWrite and Busy all 0 immediately and the FIFO empty. The next note-on writes all 5 registers (shadows invalid).
- BASE_ADDR=16'hFFFE with a note-on. Expect Incr/WaveType/PulseWidth/Sustain at addresses 0xFFFF, 0x0000, 0x0001, 0x0002 and Gate at 0xFFFE (16-bit wrap).

Source files
------------

// File: rtl/voice_bus_sequencer_if.sv
// Voice register bus plus the note-event port of voice_bus_sequencer.
// The master modport is the sequencer's view; slave is the environment's view.
interface voice_bus_sequencer_if;
    logic        EvValid;
    logic        EvReady;
    logic        EvNoteOn;
    logic [7:0]  EvIncr;
    logic [1:0]  EvWaveType;
    logic [7:0]  EvPulseWidth;
    logic [7:0]  EvSustain;
    logic [15:0] BusAddress;
    logic [7:0]  BusData;
    logic        BusReadWrite;
    logic        BusClock;
    logic        Busy;

    modport master (
        input  EvValid, EvNoteOn, EvIncr, EvWaveType, EvPulseWidth, EvSustain,
        output EvReady, BusAddress, BusData, BusReadWrite, BusClock, Busy
    );

    modport slave (
        output EvValid, EvNoteOn, EvIncr, EvWaveType, EvPulseWidth, EvSustain,
        input  EvReady, BusAddress, BusData, BusReadWrite, BusClock, Busy
    );
endinterface

// File: rtl/voice_bus_sequencer.sv
// Buffers note events in a FIFO and replays each as an ordered series of
// three-cycle register writes, skipping parameter writes that match shadows.
module voice_bus_sequencer #(
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter int unsigned DEPTH     = 4
) (
    input logic                   Clock,
    input logic                   Reset,
    voice_bus_sequencer_if.master vb
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic       note_on;
        logic [7:0] incr;
        logic [1:0] wave;
        logic [7:0] pw;
        logic [7:0] sus;
    } event_t;

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD} state_t;

    // Bit positions of the write list; ascending order is bus issue order.
    typedef enum logic [2:0] {
        IT_GATE_OFF, IT_INCR, IT_WAVE, IT_PW, IT_SUS, IT_GATE_ON
    } item_t;

    state_t      state_q, state_d;
    item_t       cur_q, cur_d, nxt;
    logic [5:0]  pend_q, pend_d, list;
    event_t      fifo_q [DEPTH];
    event_t      ev_in, work_q;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        ready_q, ready_d, empty, push, pop;
    logic [7:0]  sh_incr_q, sh_pw_q, sh_sus_q;
    logic [1:0]  sh_wave_q;
    logic [3:0]  sh_vld_q;
    logic        gate_q;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d, bclk_q, bclk_d, busy_q, busy_d;

    function automatic item_t first_item(input logic [5:0] mask);
        item_t      r;
        logic [2:0] idx;
        r = IT_GATE_OFF;
        for (int unsigned i = 0; i < 6; i++) begin
            idx = 3'(5 - i);
            if (mask[idx]) r = item_t'(idx);
        end
        return r;
    endfunction

    function automatic logic [15:0] item_offset(input item_t it);
        case (it)
            IT_INCR: return 16'd1;
            IT_WAVE: return 16'd2;
            IT_PW:   return 16'd3;
            IT_SUS:  return 16'd4;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [7:0] item_data(input item_t it, input event_t ev);
        case (it)
            IT_INCR:    return ev.incr;
            IT_WAVE:    return {6'b0, ev.wave};
            IT_PW:      return ev.pw;
            IT_SUS:     return ev.sus;
            IT_GATE_ON: return 8'h01;
            default:    return 8'h00;
        endcase
    endfunction

    assign ev_in    = {vb.EvNoteOn, vb.EvIncr, vb.EvWaveType, vb.EvPulseWidth, vb.EvSustain};
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push     = vb.EvValid && ready_q;
    assign pop      = (state_q == IDLE) && !empty;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    // EvReady is registered: it reflects fullness after this cycle's push/pop.
    assign ready_d  = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));

    always_comb begin
        list = '0;
        list[IT_GATE_OFF] = gate_q;
        if (work_q.note_on) begin
            list[IT_INCR]    = !(sh_vld_q[0] && sh_incr_q == work_q.incr);
            list[IT_WAVE]    = !(sh_vld_q[1] && sh_wave_q == work_q.wave);
            list[IT_PW]      = !(sh_vld_q[2] && sh_pw_q == work_q.pw);
            list[IT_SUS]     = !(sh_vld_q[3] && sh_sus_q == work_q.sus);
            list[IT_GATE_ON] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        nxt     = IT_GATE_OFF;
        case (state_q)
            IDLE: if (!empty) state_d = LOAD;
            LOAD: begin
                if (list != '0) begin
                    nxt     = first_item(list);
                    cur_d   = nxt;
                    pend_d  = list & ~(6'd1 << nxt);
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                if (pend_q != '0) begin
                    nxt     = first_item(pend_q);
                    cur_d   = nxt;
                    pend_d  = pend_q & ~(6'd1 << nxt);
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        addr_d = '0;
        data_d = '0;
        rw_d   = 1'b0;
        bclk_d = 1'b0;
        busy_d = (state_d != IDLE);
        if (state_d == SETUP || state_d == STROBE || state_d == HOLD) begin
            rw_d   = 1'b1;
            addr_d = BASE_ADDR + item_offset(cur_d);
            data_d = item_data(cur_d, work_q);
            bclk_d = (state_d == STROBE);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= ev_in;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            cur_q     <= IT_GATE_OFF;
            pend_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ready_q   <= 1'b1;
            work_q    <= '0;
            sh_incr_q <= '0;
            sh_wave_q <= '0;
            sh_pw_q   <= '0;
            sh_sus_q  <= '0;
            sh_vld_q  <= '0;
            gate_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
            bclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rw_q     <= rw_d;
            bclk_q   <= bclk_d;
            busy_q   <= busy_d;
            if (pop) work_q <= fifo_q[rd_ptr_q[AW-1:0]];
            if (state_q == HOLD) begin
                case (cur_q)
                    IT_GATE_OFF: gate_q <= 1'b0;
                    IT_INCR:     begin sh_incr_q <= work_q.incr; sh_vld_q[0] <= 1'b1; end
                    IT_WAVE:     begin sh_wave_q <= work_q.wave; sh_vld_q[1] <= 1'b1; end
                    IT_PW:       begin sh_pw_q   <= work_q.pw;   sh_vld_q[2] <= 1'b1; end
                    IT_SUS:      begin sh_sus_q  <= work_q.sus;  sh_vld_q[3] <= 1'b1; end
                    IT_GATE_ON:  gate_q <= 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    assign vb.EvReady      = ready_q;
    assign vb.BusAddress   = addr_q;
    assign vb.BusData      = data_q;
    assign vb.BusReadWrite = rw_q;
    assign vb.BusClock     = bclk_q;
    assign vb.Busy         = busy_q;

endmodule

// File: tb/tb_voice_bus_sequencer.sv
// Scoreboard bench for voice_bus_sequencer: expected writes are queued with
// each event, monitors pop and compare on every BusClock rising edge.
module tb_voice_bus_sequencer;

    logic Clock;
    logic Reset;

    voice_bus_sequencer_if bus_a();
    voice_bus_sequencer_if bus_b();

    voice_bus_sequencer #(.BASE_ADDR(16'h0010), .DEPTH(4)) u_dut (
        .Clock(Clock), .Reset(Reset), .vb(bus_a)
    );

    voice_bus_sequencer #(.BASE_ADDR(16'hFFFE), .DEPTH(4)) u_dut_wrap (
        .Clock(Clock), .Reset(Reset), .vb(bus_b)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    int  total    = 0;
    int  bad      = 0;
    int  writes_a = 0;
    int  writes_b = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic void expect_a(input logic [15:0] a, input logic [7:0] d);
        exp_a.push_back({a, d});
    endfunction

    function automatic void expect_b(input logic [15:0] a, input logic [7:0] d);
        exp_b.push_back({a, d});
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic push(input bit sel, input logic on, input logic [7:0] incr,
                        input logic [1:0] wave, input logic [7:0] pw,
                        input logic [7:0] sus, output int waited);
        waited = 0;
        if (sel) begin
            bus_b.EvValid = 1'b1; bus_b.EvNoteOn = on; bus_b.EvIncr = incr;
            bus_b.EvWaveType = wave; bus_b.EvPulseWidth = pw; bus_b.EvSustain = sus;
        end else begin
            bus_a.EvValid = 1'b1; bus_a.EvNoteOn = on; bus_a.EvIncr = incr;
            bus_a.EvWaveType = wave; bus_a.EvPulseWidth = pw; bus_a.EvSustain = sus;
        end
        while (!(sel ? bus_b.EvReady : bus_a.EvReady) && waited < 50) begin
            @(posedge Clock); #1;
            waited++;
        end
        if (waited >= 50) begin
            total++; bad++;
            $display("FAIL push_timeout: EvReady=0 for %0d cycles, required 1", waited);
        end else begin
            @(posedge Clock); #1;
        end
        bus_a.EvValid = 1'b0;
        bus_b.EvValid = 1'b0;
    endtask

    task automatic count_busy(input bit sel, input int start, output int n);
        int guard;
        guard = 0;
        n = start;
        while ((sel ? bus_b.Busy : bus_a.Busy) && guard < 200) begin
            n++;
            @(posedge Clock); #1;
            guard++;
        end
        if (guard >= 200) begin
            total++; bad++;
            $display("FAIL busy_timeout: Busy=1 after %0d cycles, required 0", guard);
        end
    endtask

    task automatic drain_a;
        int guard;
        guard = 0;
        while ((exp_a.size() != 0 || bus_a.Busy) && guard < 400) begin
            @(posedge Clock); #1;
            guard++;
        end
        if (guard >= 400) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_a.size());
        end
        repeat (5) begin @(posedge Clock); #1; end
    endtask

    initial begin
        logic        prev_clk, hold_chk;
        logic [15:0] prev_addr, s_addr;
        logic [7:0]  prev_data, s_data;
        wr_t         e;
        prev_clk = 1'b0; hold_chk = 1'b0;
        prev_addr = '0; prev_data = '0; s_addr = '0; s_data = '0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                prev_clk = 1'b0;
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    check("hold_busclock", bus_a.BusClock, 1'b0);
                    check("hold_rw", bus_a.BusReadWrite, 1'b1);
                    check("hold_addr", bus_a.BusAddress, s_addr);
                    check("hold_data", bus_a.BusData, s_data);
                    hold_chk = 1'b0;
                end
                if (bus_a.BusClock && !prev_clk) begin
                    writes_a++;
                    check("strobe_rw", bus_a.BusReadWrite, 1'b1);
                    check("setup_addr", prev_addr, bus_a.BusAddress);
                    check("setup_data", prev_data, bus_a.BusData);
                    if (exp_a.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_write: got 0x%0h=0x%0h, required no write",
                                 bus_a.BusAddress, bus_a.BusData);
                    end else begin
                        e = exp_a.pop_front();
                        check("write_addr", bus_a.BusAddress, e.a);
                        check("write_data", bus_a.BusData, e.d);
                    end
                    s_addr = bus_a.BusAddress;
                    s_data = bus_a.BusData;
                    hold_chk = 1'b1;
                end
                prev_clk  = bus_a.BusClock;
                prev_addr = bus_a.BusAddress;
                prev_data = bus_a.BusData;
            end
        end
    end

    initial begin
        logic prev_clk;
        wr_t  e;
        prev_clk = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Reset) begin
                prev_clk = 1'b0;
            end else begin
                if (bus_b.BusClock && !prev_clk) begin
                    writes_b++;
                    if (exp_b.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_write_wrap: got 0x%0h=0x%0h, required no write",
                                 bus_b.BusAddress, bus_b.BusData);
                    end else begin
                        e = exp_b.pop_front();
                        check("wrap_addr", bus_b.BusAddress, e.a);
                        check("wrap_data", bus_b.BusData, e.d);
                    end
                end
                prev_clk = bus_b.BusClock;
            end
        end
    end

    initial begin
        int n, w, strobes, guard;
        Reset = 1'b0;
        bus_a.EvValid = 1'b0; bus_a.EvNoteOn = 1'b0; bus_a.EvIncr = '0;
        bus_a.EvWaveType = '0; bus_a.EvPulseWidth = '0; bus_a.EvSustain = '0;
        bus_b.EvValid = 1'b0; bus_b.EvNoteOn = 1'b0; bus_b.EvIncr = '0;
        bus_b.EvWaveType = '0; bus_b.EvPulseWidth = '0; bus_b.EvSustain = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_addr", bus_a.BusAddress, 16'h0000);
        check("rst_data", bus_a.BusData, 8'h00);
        check("rst_rw", bus_a.BusReadWrite, 1'b0);
        check("rst_busclock", bus_a.BusClock, 1'b0);
        check("rst_busy", bus_a.Busy, 1'b0);
        check("rst_evready", bus_a.EvReady, 1'b1);
        Reset = 1'b1;
        @(posedge Clock); #1;

        // Full note-on from reset with latency checks.
        expect_a(16'h0011, 8'h0F); expect_a(16'h0012, 8'h01); expect_a(16'h0013, 8'h3F);
        expect_a(16'h0014, 8'h7F); expect_a(16'h0010, 8'h01);
        push(1'b0, 1'b1, 8'h0F, 2'd1, 8'h3F, 8'h7F, w);
        check("t1_idle_busy", bus_a.Busy, 1'b0);
        @(posedge Clock); #1;
        check("t1_load_busy", bus_a.Busy, 1'b1);
        check("t1_load_rw", bus_a.BusReadWrite, 1'b0);
        @(posedge Clock); #1;
        check("t1_setup_rw", bus_a.BusReadWrite, 1'b1);
        check("t1_setup_busclock", bus_a.BusClock, 1'b0);
        check("t1_setup_addr", bus_a.BusAddress, 16'h0011);
        @(posedge Clock); #1;
        check("t1_strobe_busclock", bus_a.BusClock, 1'b1);
        count_busy(1'b0, 2, n);
        check("t1_busy_cycles", n, 16);
        check("t1_idle_addr", bus_a.BusAddress, 16'h0000);
        check("t1_scoreboard", exp_a.size(), 0);

        // Retrigger: gate off, changed params only, gate on.
        expect_a(16'h0010, 8'h00); expect_a(16'h0011, 8'h05);
        expect_a(16'h0013, 8'h7F); expect_a(16'h0010, 8'h01);
        push(1'b0, 1'b1, 8'h05, 2'd1, 8'h7F, 8'h7F, w);
        @(posedge Clock); #1;
        count_busy(1'b0, 0, n);
        check("t2_busy_cycles", n, 13);
        check("t2_scoreboard", exp_a.size(), 0);

        // Note-off closes gate; second note-off is dropped.
        expect_a(16'h0010, 8'h00);
        push(1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, w);
        @(posedge Clock); #1;
        count_busy(1'b0, 0, n);
        check("t3_off_busy_cycles", n, 4);
        push(1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, w);
        @(posedge Clock); #1;
        count_busy(1'b0, 0, n);
        check("t3_drop_busy_cycles", n, 1);
        check("t3_scoreboard", exp_a.size(), 0);
        check("t3_write_count", writes_a, 10);

        // Back-pressure: FIFO fills while E0 is sequenced.
        expect_a(16'h0011, 8'h20); expect_a(16'h0012, 8'h02); expect_a(16'h0010, 8'h01);
        expect_a(16'h0010, 8'h00);
        expect_a(16'h0011, 8'h21); expect_a(16'h0013, 8'h40); expect_a(16'h0014, 8'h10);
        expect_a(16'h0010, 8'h01);
        expect_a(16'h0010, 8'h00); expect_a(16'h0010, 8'h01);
        expect_a(16'h0010, 8'h00);
        push(1'b0, 1'b1, 8'h20, 2'd2, 8'h7F, 8'h7F, w);
        @(posedge Clock); #1;
        push(1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, w);
        push(1'b0, 1'b1, 8'h21, 2'd2, 8'h40, 8'h10, w);
        push(1'b0, 1'b1, 8'h21, 2'd2, 8'h40, 8'h10, w);
        push(1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, w);
        check("t4_full_evready", bus_a.EvReady, 1'b0);
        push(1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 8'h00, w);
        check("t4_e5_wait_cycles", w, 7);
        check("t4_e5_refull_evready", bus_a.EvReady, 1'b0);
        check("t4_e1_setup_rw", bus_a.BusReadWrite, 1'b1);
        check("t4_e1_setup_addr", bus_a.BusAddress, 16'h0010);
        drain_a();
        check("t4_scoreboard", exp_a.size(), 0);
        check("t4_write_count", writes_a, 21);

        // Reset during STROBE of second write; a queued event is discarded.
        expect_a(16'h0011, 8'h33); expect_a(16'h0012, 8'h03); expect_a(16'h0013, 8'h44);
        expect_a(16'h0014, 8'h55); expect_a(16'h0010, 8'h01);
        push(1'b0, 1'b1, 8'h33, 2'd3, 8'h44, 8'h55, w);
        push(1'b0, 1'b1, 8'h66, 2'd0, 8'h66, 8'h66, w);
        strobes = 0;
        guard = 0;
        while (strobes < 2 && guard < 100) begin
            @(posedge Clock); #1;
            guard++;
            if (bus_a.BusClock) strobes++;
        end
        check("t5_reached_second_strobe", strobes, 2);
        Reset = 1'b0;
        #1;
        check("t5_rst_busclock", bus_a.BusClock, 1'b0);
        check("t5_rst_rw", bus_a.BusReadWrite, 1'b0);
        check("t5_rst_busy", bus_a.Busy, 1'b0);
        check("t5_rst_addr", bus_a.BusAddress, 16'h0000);
        check("t5_rst_evready", bus_a.EvReady, 1'b1);
        check("t5_writes_before_reset", writes_a, 22);
        exp_a.delete();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (5) begin @(posedge Clock); #1; end
        check("t5_fifo_empty_busy", bus_a.Busy, 1'b0);
        expect_a(16'h0011, 8'h33); expect_a(16'h0012, 8'h03); expect_a(16'h0013, 8'h44);
        expect_a(16'h0014, 8'h55); expect_a(16'h0010, 8'h01);
        push(1'b0, 1'b1, 8'h33, 2'd3, 8'h44, 8'h55, w);
        @(posedge Clock); #1;
        count_busy(1'b0, 0, n);
        check("t5_busy_cycles", n, 16);
        check("t5_scoreboard", exp_a.size(), 0);

        // 16-bit address wrap on the second instance.
        expect_b(16'hFFFF, 8'h01); expect_b(16'h0000, 8'h02); expect_b(16'h0001, 8'h03);
        expect_b(16'h0002, 8'h04); expect_b(16'hFFFE, 8'h01);
        push(1'b1, 1'b1, 8'h01, 2'd2, 8'h03, 8'h04, w);
        @(posedge Clock); #1;
        count_busy(1'b1, 0, n);
        check("t6_busy_cycles", n, 16);
        repeat (3) begin @(posedge Clock); #1; end
        check("t6_scoreboard", exp_b.size(), 0);
        check("final_write_count_a", writes_a, 27);
        check("final_write_count_b", writes_b, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
